// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: STAGE-deep add/subtract pipeline of 4-bit CLA groups with valid/ready flow control.
// Define CLA_OVERFLOW_EN to add the o_overflow port (signed overflow aligned with o_data_s).
module pipelined_cla_adder #(
  parameter int BIT   = 32,
  parameter int STAGE = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [BIT-1:0] i_data_a,
  input  logic [BIT-1:0] i_data_b,
  input  logic           i_carry,
  input  logic           i_mode,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [BIT-1:0] o_data_s,
  output logic           o_carry
`ifdef CLA_OVERFLOW_EN
  ,
  output logic           o_overflow
`endif
);
  localparam int SW = BIT / STAGE;
  localparam int GN = SW / 4;
  // Each rank carries the operands, the sum bits completed so far and the carry into the next slice.
  typedef struct packed {
    logic           v;
    logic [BIT-1:0] a;
    logic [BIT-1:0] b;
    logic [BIT-1:0] s;
    logic           c;
  } rank_t;
  rank_t rank_q [STAGE];
  rank_t rank_d [STAGE];
  rank_t first;
  logic  stall;
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g = a & b;
    p = a | b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction
  // Sum slice k of a rank, chaining the groups inside the slice.
  function automatic rank_t step(input rank_t r, input int k);
    rank_t o;
    logic [4:0] t;
    o = r;
    for (int j = 0; j < GN; j++) begin
      t = cla4(r.a[k*SW+4*j +: 4], r.b[k*SW+4*j +: 4], o.c);
      o.s[k*SW+4*j +: 4] = t[3:0];
      o.c = t[4];
    end
    return o;
  endfunction
  always_comb begin
    stall = rank_q[STAGE-1].v && !i_ready;
    first.v = i_valid;
    first.a = i_data_a;
    first.b = i_mode ? ~i_data_b : i_data_b;
    first.s = '0;
    first.c = i_mode | i_carry;
    rank_d[0] = stall ? rank_q[0] : step(first, 0);
    for (int k = 1; k < STAGE; k++)
      rank_d[k] = stall ? rank_q[k] : step(rank_q[k-1], k);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      for (int k = 0; k < STAGE; k++) rank_q[k] <= '0;
    else
      for (int k = 0; k < STAGE; k++) rank_q[k] <= rank_d[k];
  end
  assign o_ready  = !stall;
  assign o_valid  = rank_q[STAGE-1].v;
  assign o_data_s = rank_q[STAGE-1].s;
  assign o_carry  = rank_q[STAGE-1].c;
`ifdef CLA_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;
  // a^b^s at the MSB recovers the carry into the MSB.
  always_comb ovf_d = stall ? ovf_q : rank_d[STAGE-1].a[BIT-1] ^ rank_d[STAGE-1].b[BIT-1]
                                    ^ rank_d[STAGE-1].s[BIT-1] ^ rank_d[STAGE-1].c;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign o_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed vector table, stall/reset sequences and a randomized scoreboard run.
module tb_pipelined_cla_adder;
  localparam int BIT   = 32;
  localparam int STAGE = 2;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_carry = 0, i_mode = 0, i_ready = 1;
  logic [BIT-1:0] i_data_a = '0, i_data_b = '0;
  logic o_ready, o_valid, o_carry;
  logic [BIT-1:0] o_data_s;
`ifdef CLA_OVERFLOW_EN
  logic o_overflow;
`endif
  pipelined_cla_adder #(.BIT(BIT), .STAGE(STAGE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_carry(i_carry), .i_mode(i_mode),
    .o_valid(o_valid), .i_ready(i_ready), .o_data_s(o_data_s), .o_carry(o_carry)
`ifdef CLA_OVERFLOW_EN
    , .o_overflow(o_overflow)
`endif
  );
  always #5 i_clk = ~i_clk;
  int vec = 0, errs = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                       input logic cin, input logic mode);
    i_valid = v; i_data_a = a; i_data_b = b; i_carry = cin; i_mode = mode;
  endtask
  typedef struct {
    logic [BIT-1:0] s;
    logic           c;
    logic           o;
  } res_t;
  // Reference: plain integer arithmetic, signed overflow from range check.
  function automatic res_t model(input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                                 input logic cin, input logic mode);
    res_t r;
    logic [BIT:0] w;
    longint sr;
    w = mode ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b} + {32'd0, cin};
    sr = mode ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    r.s = w[BIT-1:0];
    r.c = w[BIT];
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction
  typedef struct {
    logic [BIT-1:0] a, b;
    logic cin, mode;
    logic [BIT-1:0] s;
    logic c, ovf;
  } vec_t;
  vec_t tbl[10];
  res_t q[$];
  logic mon_en = 0, prev_stall = 0, prev_c = 0;
  logic [BIT-1:0] prev_s = '0;
  always @(posedge i_clk) begin
    if (mon_en && !i_rst) begin
      if (prev_stall) begin
        chk("stall_hold_s", {32'd0, o_data_s}, {32'd0, prev_s});
        chk("stall_hold_c", {63'd0, o_carry}, {63'd0, prev_c});
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else begin
          res_t e;
          e = q.pop_front();
          chk("rand_s", {32'd0, o_data_s}, {32'd0, e.s});
          chk("rand_c", {63'd0, o_carry}, {63'd0, e.c});
`ifdef CLA_OVERFLOW_EN
          chk("rand_ovf", {63'd0, o_overflow}, {63'd0, e.o});
`endif
        end
      end
      if (i_valid && o_ready) q.push_back(model(i_data_a, i_data_b, i_carry, i_mode));
      prev_stall = o_valid && !i_ready;
      prev_s = o_data_s;
      prev_c = o_carry;
    end
  end
  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[2] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    tbl[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    tbl[9] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    repeat (2) tick();
    i_rst = 0;
    #1;
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_data", {32'd0, o_data_s}, 64'd0);
    chk("rst_carry", {63'd0, o_carry}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
`ifdef CLA_OVERFLOW_EN
    chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
`endif
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].mode);
      tick();
      i_valid = 0;
      chk($sformatf("v%0d_early", i), {63'd0, o_valid}, 64'd0);
      tick();
      chk($sformatf("v%0d_valid", i), {63'd0, o_valid}, 64'd1);
      chk($sformatf("v%0d_s", i), {32'd0, o_data_s}, {32'd0, tbl[i].s});
      chk($sformatf("v%0d_c", i), {63'd0, o_carry}, {63'd0, tbl[i].c});
`ifdef CLA_OVERFLOW_EN
      chk($sformatf("v%0d_ovf", i), {63'd0, o_overflow}, {63'd0, tbl[i].ovf});
`endif
    end
    tick();
    // Backpressure: 1+1, 2+2, 3+3 with a 4-cycle stall on the first result.
    drive(1, 32'd1, 32'd1, 0, 0);
    tick();
    drive(1, 32'd2, 32'd2, 0, 0);
    tick();
    drive(1, 32'd3, 32'd3, 0, 0);
    i_ready = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", {63'd0, o_ready}, 64'd0);
      chk("bp_valid", {63'd0, o_valid}, 64'd1);
      chk("bp_hold", {32'd0, o_data_s}, 64'd2);
      tick();
    end
    i_ready = 1;
    #1;
    chk("bp_out0", {31'd0, o_valid, o_data_s}, {31'd1, 32'd2});
    tick();
    i_valid = 0;
    chk("bp_out1", {31'd0, o_valid, o_data_s}, {31'd1, 32'd4});
    tick();
    chk("bp_out2", {31'd0, o_valid, o_data_s}, {31'd1, 32'd6});
    tick();
    chk("bp_empty", {63'd0, o_valid}, 64'd0);
    // Reset while two operands are in flight.
    drive(1, 32'd10, 32'd20, 0, 0);
    tick();
    drive(1, 32'd30, 32'd40, 0, 0);
    @(posedge i_clk);
    i_rst = 1;
    #1;
    i_valid = 0;
    chk("mrst_valid", {63'd0, o_valid}, 64'd0);
    tick();
    i_rst = 0;
    for (int i = 0; i < 4; i++) begin
      chk("mrst_none", {63'd0, o_valid}, 64'd0);
      tick();
    end
    chk("mrst_ready", {63'd0, o_ready}, 64'd1);
    // Randomized run against the reference model, starting with a full-throughput burst.
    mon_en = 1;
    for (int n = 0; n < 20; n++) begin
      drive(1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      i_ready = 1;
      tick();
      if (n >= STAGE - 1) chk("throughput", {63'd0, o_valid}, 64'd1);
    end
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      i_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    i_valid = 0;
    i_ready = 1;
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
